// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   INSTR_NOP     : canonical no-op encoding (addi x0,x0,0)
//   PC_INC        : byte stride between sequential instructions
//   fetch_entry_t : one decode-bound queue entry, {pc, instr}
package fetch_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : empties the FIFO (wins over push/pop)
//   push/din : write an element (caller guarantees not full)
//   pop      : drop the head (caller guarantees not empty)
//   dout     : head element, straight from the storage flops
//   count    : number of stored elements
module fetch_queue #(
  parameter type T     = logic,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic [CW-1:0] count
);
  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues word fetches at pc_in, pairs in-order
// responses with their PCs, queues them and hands them to decode.
//   clk, rst                 : clock, asynchronous active-high reset
//   pc_in / inc_pc / pc_hold : PC register interface
//   flush                    : redirect; discards queued and in-flight fetches
//   imem_*                   : req/gnt request channel, rvalid/rdata responses
//   instr_valid/ready, instr, instr_pc : decode handshake, head of queue
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DATA_WIDTH    = DATA_W,
  parameter int QUEUE_DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pc_in,
  output logic [ADDRESS_WIDTH-1:0] inc_pc,
  output logic                     pc_hold,
  input  logic                     flush,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [CW-1:0]            count, outstanding, drop, pend_count;
  logic [CW:0]              inflight;
  logic                     issue, pop, rsp, dropping, keep;
  logic [ADDRESS_WIDTH-1:0] pend_pc;
  fetch_entry_t             q_in, q_out;

  assign pop = instr_valid && instr_ready;

  // An entry leaving to decode this cycle frees its slot, so it is credited
  // back immediately; without that a 2-deep queue could only sustain two
  // instructions every three cycles. The queue still can never overflow.
  assign inflight  = (CW+1)'(outstanding) + (CW+1)'(count) - (CW+1)'(pop);
  assign imem_req  = !rst && !flush && (inflight < (CW+1)'(QUEUE_DEPTH));
  assign imem_addr = pc_in;
  assign issue     = imem_req && imem_gnt;
  assign pc_hold   = !issue;
  assign inc_pc    = pc_in + ADDRESS_WIDTH'(PC_INC);

  // A response with nothing outstanding can only be a stray from before a
  // reset; it is ignored rather than allowed to underflow the counters.
  assign rsp      = imem_rvalid && (outstanding != '0);
  assign dropping = rsp && (drop != '0);
  assign keep     = rsp && (drop == '0) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else if (flush) begin
      // No issue can happen under flush; everything still in flight is junk.
      outstanding <= outstanding - CW'(rsp);
      drop        <= outstanding - CW'(rsp);
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rsp);
      if (dropping) drop <= drop - CW'(1);
    end
  end

  // PCs of issued fetches, oldest first; dropped responses have no entry
  // here because the flush that made them stale also cleared this FIFO.
  fetch_queue #(.T(logic [ADDRESS_WIDTH-1:0]), .DEPTH(QUEUE_DEPTH)) u_pend (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .push (issue),
    .din  (pc_in),
    .pop  (rsp && (drop == '0) && (pend_count != '0)),
    .dout (pend_pc),
    .count(pend_count)
  );

  assign q_in = '{pc: pend_pc, instr: imem_rdata};

  fetch_queue #(.T(fetch_entry_t), .DEPTH(QUEUE_DEPTH)) u_iq (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .push (keep),
    .din  (q_in),
    .pop  (pop),
    .dout (q_out),
    .count(count)
  );

  assign instr_valid = (count != '0);
  assign instr       = q_out.instr;
  assign instr_pc    = q_out.pc;
endmodule
